lc4_wb_queue_ss: RTL and testbench
==================================

Name: lc4_wb_queue_ss

Overview:
Two-wide in-order writeback queue that sits in front of the superscalar register file's two write ports. It accepts up to two completed results per cycle from pipes A and B, buffers them in program order, and drains up to two per cycle onto the regfile write ports. The older entry always goes on port A and the younger on port B, so the regfile's "B wins" rule resolves same-rd writes correctly. It also reports, per decode read selector, whether a register still has an undrained pending write, which the stall logic uses.

Parameters:
n, 16, data width of each result.
DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
gwe  input  1  global write enable; no state changes while low
i_in_valid_A  input  1  pipe A result valid (older of the pair)
i_in_rd_A  input  3  pipe A destination register
i_in_data_A  input  n  pipe A result
i_in_valid_B  input  1  pipe B result valid (younger of the pair)
i_in_rd_B  input  3  pipe B destination register
i_in_data_B  input  n  pipe B result
o_in_ready  output  1  queue can accept two entries this cycle
i_drain_en  input  1  permission to write the regfile this cycle
o_rd_A  output  3  regfile port A selector (head entry)
o_wdata_A  output  n  regfile port A data
o_rd_we_A  output  1  regfile port A write enable
o_rd_B  output  3  regfile port B selector (head+1 entry)
o_wdata_B  output  n  regfile port B data
o_rd_we_B  output  1  regfile port B write enable
i_chk_rs_A, i_chk_rt_A, i_chk_rs_B, i_chk_rt_B  input  3 each  decode read selectors to check
o_pending  output  4  bit0..3 = rs_A, rt_A, rs_B, rt_B has a pending write
o_count  output  log2(DEPTH)+1  valid entries
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH

Behaviour:
- Reset (rst high at a clk edge with gwe high or low): head=0, tail=0, count=0.
  - Contents are discarded; reset mid-operation drops all entries.
  - After reset: o_rd_we_A=o_rd_we_B=0, o_pending=0, o_empty=1, o_full=0, o_in_ready=1.
- o_in_ready = (DEPTH - count) >= 2, computed from registered count only; same-cycle drain does not raise it.
- Enqueue occurs on a clk edge with gwe=1, rst=0, o_in_ready=1:
  - A valid only: A written at tail, tail+=1.
  - B valid only: B written at tail, tail+=1.
  - Both valid: A at tail, B at tail+1, tail+=2.
  - Valid inputs while o_in_ready=0 are ignored; upstream must hold them.
- Drain outputs are combinational from registered state:
  - o_rd_we_A = i_drain_en & (count>=1); o_rd_A/o_wdata_A = entry[head].
  - o_rd_we_B = i_drain_en & (count>=2); o_rd_B/o_wdata_B = entry[head+1].
  - Selector/data outputs are undefined-but-stable (entry contents) when their we is 0.
- Dequeue on the gwe edge: head += number of asserted write enables (0, 1 or 2).
- Simultaneous enqueue and dequeue is legal: count_next = count + enq - deq.
- Pointers wrap modulo DEPTH.
- Latency: a result enqueued at edge t appears on the write ports in cycle t+1 at the earliest; program order is preserved.
- Same rd on A and B in one drain cycle: both enables asserted; port B holds the younger entry.
- o_pending[k] = 1 iff some valid entry, not being drained this cycle (index >= number of asserted enables), has rd == the selector for bit k.
  - Entries draining this cycle are excluded because the regfile bypasses them.
  - Inputs being enqueued this cycle are not included.
- gwe low: pointers, count and contents hold; all outputs still track registered state and current inputs.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, o_empty=1, o_in_ready=1, o_rd_we_A/B=0, o_pending=0.
- Dual enqueue then drain: enqueue A(rd=3,0x1111) and B(rd=5,0x2222); next cycle i_drain_en=1 -> o_rd_A=3/0x1111, o_rd_B=5/0x2222, both we=1; count 2 -> 0.
- Fill and backpressure (DEPTH=4): enqueue 2+2 with drain off -> o_full=1, o_in_ready=0; a third pair presented is not accepted and count stays 4. Enable drain -> entries exit in order across the pointer wrap.
- Same-rd ordering: enqueue A(rd=2,0xAAAA) and B(rd=2,0xBBBB), then drain -> both on ports A/B with 0xBBBB on B; the regfile then reads r2=0xBBBB.
- Pending check: queue holds rd=4 and rd=6, drain off, i_chk_rs_A=4, i_chk_rt_B=6 -> o_pending=4'b1001. Raise i_drain_en -> o_pending=0 in the same cycle.
- gwe gating: hold gwe=0 with valid inputs and i_drain_en=1 -> count unchanged for 3 cycles; gwe=1 -> enqueue and dequeue occur.

Source files
------------

// File: rtl/lc4_wb_queue_ss.sv
`default_nettype none
// ============================================================================
// Module   : lc4_wb_queue_ss
// Purpose  : Two-wide in-order writeback queue placed in front of the
//            superscalar register file's two write ports.
//            - Accepts up to two results per cycle. Pipe A is the older
//              result and pipe B is the younger result.
//            - Drains up to two entries per cycle. The older entry is sent
//              on port A and the younger entry on port B.
//            - Reports which decode read selectors still have an undrained
//              write pending.
// Ports    : clk, rst (sync, active high), gwe (global write enable)
//            i_in_valid/rd/data_A|B : results from pipes A and B
//            o_in_ready             : two free slots are available
//            i_drain_en             : regfile write permission this cycle
//            o_rd/o_wdata/o_rd_we_A : head entry,   regfile port A
//            o_rd/o_wdata/o_rd_we_B : head+1 entry, regfile port B
//            i_chk_*                : decode selectors to check
//            o_pending              : per-selector pending-write flags
//            o_count/o_empty/o_full : occupancy
// Revision : 1.0 - initial release
// ============================================================================
module lc4_wb_queue_ss #(
  parameter int n     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gwe,
  input  logic                       i_in_valid_A,
  input  logic [2:0]                 i_in_rd_A,
  input  logic [n-1:0]               i_in_data_A,
  input  logic                       i_in_valid_B,
  input  logic [2:0]                 i_in_rd_B,
  input  logic [n-1:0]               i_in_data_B,
  output logic                       o_in_ready,
  input  logic                       i_drain_en,
  output logic [2:0]                 o_rd_A,
  output logic [n-1:0]               o_wdata_A,
  output logic                       o_rd_we_A,
  output logic [2:0]                 o_rd_B,
  output logic [n-1:0]               o_wdata_B,
  output logic                       o_rd_we_B,
  input  logic [2:0]                 i_chk_rs_A,
  input  logic [2:0]                 i_chk_rt_A,
  input  logic [2:0]                 i_chk_rs_B,
  input  logic [2:0]                 i_chk_rt_B,
  output logic [3:0]                 o_pending,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_READY = CW'(DEPTH - 2);

  logic [2:0]    rd_mem   [DEPTH];
  logic [n-1:0]  data_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic          we_a;
  logic          we_b;
  logic [1:0]    deq;
  logic [1:0]    enq;
  logic          accept;

  assign head_p1 = head + AW'(1);
  assign tail_p1 = tail + AW'(1);

  // Ready depends only on registered occupancy. This keeps the upstream
  // path free of any dependence on the drain permission.
  assign o_in_ready = (count <= MAX_READY);
  assign accept     = gwe & o_in_ready;

  assign we_a = i_drain_en & (count != '0);
  assign we_b = i_drain_en & (count >= CW'(2));

  assign deq = {1'b0, we_a} + {1'b0, we_b};
  assign enq = accept ? ({1'b0, i_in_valid_A} + {1'b0, i_in_valid_B}) : 2'd0;

  assign o_rd_we_A = we_a;
  assign o_rd_A    = rd_mem[head];
  assign o_wdata_A = data_mem[head];
  assign o_rd_we_B = we_b;
  assign o_rd_B    = rd_mem[head_p1];
  assign o_wdata_B = data_mem[head_p1];

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == DEPTH_C);

  // The pointers advance modulo DEPTH because they are exactly AW bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (gwe) begin
      head  <= head + AW'(deq);
      tail  <= tail + AW'(enq);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Storage is not reset. Entries outside [head, head+count) are never
  // treated as valid.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (i_in_valid_A) begin
        rd_mem[tail]   <= i_in_rd_A;
        data_mem[tail] <= i_in_data_A;
        if (i_in_valid_B) begin
          rd_mem[tail_p1]   <= i_in_rd_B;
          data_mem[tail_p1] <= i_in_data_B;
        end
      end else if (i_in_valid_B) begin
        rd_mem[tail]   <= i_in_rd_B;
        data_mem[tail] <= i_in_data_B;
      end
    end
  end

  // Pending-write search is indexed by age, where offset j = head + j.
  // Offsets below deq are being written to the regfile this cycle. The
  // regfile bypasses those writes, so they do not count as pending.
  logic [3:0] hit [DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_pend
    logic [AW-1:0] slot;
    logic          live;
    assign slot   = head + AW'(j);
    assign live   = (CW'(j) < count) && (CW'(j) >= CW'(deq));
    assign hit[j] = {4{live}} & {(rd_mem[slot] == i_chk_rt_B),
                                 (rd_mem[slot] == i_chk_rs_B),
                                 (rd_mem[slot] == i_chk_rt_A),
                                 (rd_mem[slot] == i_chk_rs_A)};
  end

  always_comb begin
    o_pending = 4'b0000;
    for (int k = 0; k < DEPTH; k++) begin
      o_pending = o_pending | hit[k];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lc4_wb_queue_ss.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_wb_queue_ss
// Purpose  : Directed testbench for lc4_wb_queue_ss (n=16, DEPTH=4).
//            Each check compares a DUT output against a hand-computed value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_wb_queue_ss;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        in_valid_a, in_valid_b;
  logic [2:0]  in_rd_a, in_rd_b;
  logic [15:0] in_data_a, in_data_b;
  logic        in_ready;
  logic        drain_en;
  logic [2:0]  rd_a, rd_b;
  logic [15:0] wdata_a, wdata_b;
  logic        we_a, we_b;
  logic [2:0]  chk_rs_a, chk_rt_a, chk_rs_b, chk_rt_b;
  logic [3:0]  pending;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;
  logic [15:0] rf [8];

  always #5 clk = ~clk;

  lc4_wb_queue_ss #(.n(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_in_valid_A(in_valid_a), .i_in_rd_A(in_rd_a), .i_in_data_A(in_data_a),
    .i_in_valid_B(in_valid_b), .i_in_rd_B(in_rd_b), .i_in_data_B(in_data_b),
    .o_in_ready(in_ready), .i_drain_en(drain_en),
    .o_rd_A(rd_a), .o_wdata_A(wdata_a), .o_rd_we_A(we_a),
    .o_rd_B(rd_b), .o_wdata_B(wdata_b), .o_rd_we_B(we_b),
    .i_chk_rs_A(chk_rs_a), .i_chk_rt_A(chk_rt_a),
    .i_chk_rs_B(chk_rs_b), .i_chk_rt_B(chk_rt_b),
    .o_pending(pending), .o_count(count), .o_empty(empty), .o_full(full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Checks run 1 time
  // unit after that, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_in(input logic va, input logic [2:0] ra, input logic [15:0] da,
                        input logic vb, input logic [2:0] rb, input logic [15:0] db);
    in_valid_a = va; in_rd_a = ra; in_data_a = da;
    in_valid_b = vb; in_rd_b = rb; in_data_b = db;
  endtask

  // Register file model. It applies port A first and then port B, so a
  // write on port B wins when both ports target the same register.
  task automatic rf_commit();
    if (we_a) rf[rd_a] = wdata_a;
    if (we_b) rf[rd_b] = wdata_b;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rst = 1'b1; gwe = 1'b1; drain_en = 1'b0;
    chk_rs_a = 3'd0; chk_rt_a = 3'd0; chk_rs_b = 3'd0; chk_rt_b = 3'd0;
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Reset, then idle.
    tick(); tick();
    rst = 1'b0; settle();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", in_ready, 1);
    check("rst_we", {we_a, we_b}, 2'b00);
    check("rst_pending", pending, 4'b0000);

    // Dual enqueue, then drain both entries.
    set_in(1'b1, 3'd3, 16'h1111, 1'b1, 3'd5, 16'h2222);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    drain_en = 1'b1; settle();
    check("dual_count2", count, 2);
    check("dual_rdA", rd_a, 3);
    check("dual_dataA", wdata_a, 16'h1111);
    check("dual_rdB", rd_b, 5);
    check("dual_dataB", wdata_b, 16'h2222);
    check("dual_we", {we_a, we_b}, 2'b11);
    tick();
    drain_en = 1'b0; settle();
    check("dual_count0", count, 0);
    check("dual_empty", empty, 1);

    // Fill the queue with backpressure. Head and tail are at 2, so the
    // second pair wraps into slots 0 and 1.
    set_in(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
    tick(); settle();
    check("fill_ready_at2", in_ready, 1);
    set_in(1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404);
    tick(); settle();
    check("fill_full", full, 1);
    check("fill_ready0", in_ready, 0);
    check("fill_count4", count, 4);
    set_in(1'b1, 3'd7, 16'h0707, 1'b1, 3'd7, 16'h0777);
    tick(); settle();
    check("fill_rejected", count, 4);
    drain_en = 1'b1; settle();
    check("fill_ready_no_bypass", in_ready, 0);
    check("wrap_rdA0", rd_a, 1);
    check("wrap_dataA0", wdata_a, 16'h0101);
    check("wrap_dataB0", wdata_b, 16'h0202);
    // The offered pair stays valid: no room is available until the next edge.
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0); settle();
    check("wrap_count2", count, 2);
    check("wrap_dataA1", wdata_a, 16'h0303);
    check("wrap_rdB1", rd_b, 4);
    check("wrap_dataB1", wdata_b, 16'h0404);
    tick(); drain_en = 1'b0; settle();
    check("wrap_empty", count, 0);

    // Single enqueue from pipe B only.
    set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h0606);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    drain_en = 1'b1; settle();
    check("single_count1", count, 1);
    check("single_we", {we_a, we_b}, 2'b10);
    check("single_rdA", rd_a, 6);
    check("single_dataA", wdata_a, 16'h0606);
    tick(); drain_en = 1'b0; settle();
    check("single_count0", count, 0);

    // Same destination register on both ports: the younger entry goes on
    // port B and ends up in r2.
    set_in(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    drain_en = 1'b1; settle();
    check("same_we", {we_a, we_b}, 2'b11);
    check("same_dataA", wdata_a, 16'hAAAA);
    check("same_rdB", rd_b, 2);
    check("same_dataB", wdata_b, 16'hBBBB);
    rf_commit();
    check("same_rf_r2", rf[2], 16'hBBBB);
    tick(); drain_en = 1'b0; settle();

    // Pending-write detection.
    chk_rs_a = 3'd4; chk_rt_b = 3'd6;
    set_in(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0); settle();
    check("pend_enq_excluded", pending, 4'b0000);
    set_in(1'b1, 3'd4, 16'h4444, 1'b1, 3'd6, 16'h6666);
    tick(); settle();
    check("pend_1001", pending, 4'b1001);
    drain_en = 1'b1; settle();
    check("pend_draining", pending, 4'b0000);
    drain_en = 1'b0;
    set_in(1'b1, 3'd4, 16'h4040, 1'b0, 3'd0, 16'h0);
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0); settle();
    check("pend_count3", count, 3);
    check("pend_ready3", in_ready, 0);
    check("pend_3_1001", pending, 4'b1001);
    drain_en = 1'b1; settle();
    check("pend_third_left", pending, 4'b0001);
    tick(); settle();
    check("pend_last_drain", pending, 4'b0000);
    check("pend_last_data", wdata_a, 16'h4040);
    tick(); drain_en = 1'b0; settle();
    check("pend_empty", count, 0);
    chk_rs_a = 3'd0; chk_rt_b = 3'd0;

    // Global write enable gating.
    set_in(1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 16'h0);
    tick();
    gwe = 1'b0; drain_en = 1'b1;
    set_in(1'b1, 3'd1, 16'h1234, 1'b1, 3'd2, 16'h5678);
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      check("gwe_hold", count, 1);
    end
    check("gwe_outputs_track", {we_a, we_b}, 2'b10);
    gwe = 1'b1;
    tick();
    set_in(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0); settle();
    check("gwe_count2", count, 2);
    check("gwe_dataA", wdata_a, 16'h1234);
    check("gwe_dataB", wdata_b, 16'h5678);

    // Reset in the middle of operation while gwe is low.
    drain_en = 1'b0; gwe = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; gwe = 1'b1; settle();
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
